// File: rtl/offnariscv_ace_rd_arbiter_if.sv
// ACE read-channel bundle (AR + R + RACK). NP>1 gives per-port AR/handshake lanes
// with a single shared R payload; NP=1 is a plain single-port read channel.
interface offnariscv_ace_rd_arbiter_if #(
  parameter int NP     = 2,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int RESP_W = 4
);
  logic [NP-1:0]             arvalid;
  logic [NP-1:0]             arready;
  logic [NP-1:0][ID_W-1:0]   arid;
  logic [NP-1:0][ADDR_W-1:0] araddr;
  logic [NP-1:0][7:0]        arlen;
  logic [NP-1:0][2:0]        arsize;
  logic [NP-1:0][1:0]        arburst;
  logic [NP-1:0][3:0]        arcache;
  logic [NP-1:0][2:0]        arprot;
  logic [NP-1:0][3:0]        arsnoop;
  logic [NP-1:0][1:0]        ardomain;
  logic [NP-1:0][1:0]        arbar;
  logic [NP-1:0]             rvalid;
  logic [NP-1:0]             rready;
  logic [ID_W-1:0]           rid;
  logic [DATA_W-1:0]         rdata;
  logic [RESP_W-1:0]         rresp;
  logic                      rlast;
  logic [NP-1:0]             rack;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, arcache, arprot,
           arsnoop, ardomain, arbar, rready, rack,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, arcache, arprot,
           arsnoop, ardomain, arbar, rready, rack,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/offnariscv_ace_rd_arbiter.sv
// N-to-1 ACE read arbiter: round-robin AR grant with a registered AR slot, in-order R
// routing through an order FIFO. Optional grant counters: OFFNARISCV_ACE_RD_ARB_PERF_EN.
module offnariscv_ace_rd_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ACE_ID_WIDTH    = 4,
  parameter int ACE_ADDR_WIDTH  = 32,
  parameter int ACE_DATA_WIDTH  = 64,
  parameter int ACE_RRESP_WIDTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  offnariscv_ace_rd_arbiter_if.slave  s,
  offnariscv_ace_rd_arbiter_if.master m,
  output logic                        err_unexp_r_o,
  output logic [NUM_PORTS-1:0][31:0]  perf_grant_cnt_o
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, REQ} state_e;

  typedef struct packed {
    logic [ACE_ID_WIDTH-1:0]   id;
    logic [ACE_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic [3:0]                cache;
    logic [2:0]                prot;
    logic [3:0]                snoop;
    logic [1:0]                domain;
    logic [1:0]                bar;
  } ar_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] win_q, win_d;
  ar_t              ar_q, ar_d;

  logic [IDX_W-1:0] win;
  logic             found;
  logic [IDX_W:0]   cand;

  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fifo_empty, fifo_full;
  logic [IDX_W-1:0] head;
  logic             push, pop;
  logic             err_q;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign head       = fifo_q[rd_q];

  // First requester at or after rr_q, scanning with wrap-around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_PORTS)) cand = cand - (IDX_W+1)'(NUM_PORTS);
      if (!found && s.arvalid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
  end

  // AR FSM: grant in IDLE, hold the registered request in REQ until accepted.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    ar_d      = ar_q;
    push      = 1'b0;
    s.arready = '0;
    case (state_q)
      IDLE: begin
        if (found && !fifo_full) begin
          s.arready[win] = 1'b1;
          win_d          = win;
          ar_d.id        = s.arid[win];
          ar_d.addr      = s.araddr[win];
          ar_d.len       = s.arlen[win];
          ar_d.size      = s.arsize[win];
          ar_d.burst     = s.arburst[win];
          ar_d.cache     = s.arcache[win];
          ar_d.prot      = s.arprot[win];
          ar_d.snoop     = s.arsnoop[win];
          ar_d.domain    = s.ardomain[win];
          ar_d.bar       = s.arbar[win];
          rr_d           = (win == IDX_W'(NUM_PORTS-1)) ? '0 : win + IDX_W'(1);
          state_d        = REQ;
        end
      end
      REQ: begin
        if (m.arready[0]) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      ar_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      ar_q    <= ar_d;
    end
  end

  assign m.arvalid[0]  = (state_q == REQ);
  assign m.arid[0]     = ar_q.id;
  assign m.araddr[0]   = ar_q.addr;
  assign m.arlen[0]    = ar_q.len;
  assign m.arsize[0]   = ar_q.size;
  assign m.arburst[0]  = ar_q.burst;
  assign m.arcache[0]  = ar_q.cache;
  assign m.arprot[0]   = ar_q.prot;
  assign m.arsnoop[0]  = ar_q.snoop;
  assign m.ardomain[0] = ar_q.domain;
  assign m.arbar[0]    = ar_q.bar;

  // R routing: only the oldest outstanding burst's port sees the beats.
  always_comb begin
    s.rvalid    = '0;
    m.rready[0] = 1'b0;
    if (!fifo_empty) begin
      s.rvalid[head] = m.rvalid[0];
      m.rready[0]    = s.rready[head];
    end
  end

  assign pop = !fifo_empty && m.rvalid[0] && m.rready[0] && m.rlast;

  assign s.rid     = m.rid;
  assign s.rdata   = m.rdata;
  assign s.rresp   = m.rresp;
  assign s.rlast   = m.rlast;
  assign m.rack[0] = |s.rack;

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_q] <= win_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // A beat with nothing outstanding is a protocol violation upstream; latch it.
  always_ff @(posedge clk_i) begin
    if (rst_i)                          err_q <= 1'b0;
    else if (fifo_empty && m.rvalid[0]) err_q <= 1'b1;
  end

  assign err_unexp_r_o = err_q;

`ifdef OFFNARISCV_ACE_RD_ARB_PERF_EN
  logic [NUM_PORTS-1:0][31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (s.arready[i]) perf_q[i] <= perf_q[i] + 32'd1;
    end
  end

  assign perf_grant_cnt_o = perf_q;
`else
  assign perf_grant_cnt_o = '0;
`endif

endmodule
